// File: rtl/pfl_fl_pkg.sv
// pfl_fl_pkg: op encodings, AMD unlock constants and FSM state types for the flash writer
package pfl_fl_pkg;
    localparam logic [1:0]  OP_PROG    = 2'b01;
    localparam logic [1:0]  OP_ERASE   = 2'b10;
    localparam logic [11:0] UNLK_ADDR1 = 12'h555;
    localparam logic [11:0] UNLK_ADDR2 = 12'h2AA;
    localparam logic [7:0]  UNLK_DATA1 = 8'hAA;
    localparam logic [7:0]  UNLK_DATA2 = 8'h55;
    localparam logic [7:0]  CMD_PROG   = 8'hA0;
    localparam logic [7:0]  CMD_ERASE  = 8'h80;
    localparam logic [7:0]  CMD_SECTOR = 8'h30;

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_UNLK1, S_UNLK2, S_CMD, S_DATA,
        S_ERS3, S_ERS4, S_ERS5, S_ERS6, S_POLL, S_REREAD, S_VERIFY, S_FIN
    } fl_state_t;

    typedef enum logic [2:0] {
        BC_IDLE, BC_SETUP, BC_WE, BC_HOLD, BC_RD, BC_REC
    } bc_phase_t;
endpackage

// File: rtl/pfl_fl_writer_if.sv
// pfl_fl_writer_if: command handshake, bus arbitration and flash pin bundle
interface pfl_fl_writer_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    logic              flash_access_granted;
    logic              flash_access_request;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              op_done;
    logic              op_error;
    logic              busy;
    logic [ADDR_W-1:0] flash_addr;
    logic [DATA_W-1:0] flash_dq_out;
    logic              flash_dq_oe;
    logic [DATA_W-1:0] flash_dq_in;
    logic              flash_nce;
    logic              flash_nwe;
    logic              flash_noe;

    modport slave (
        input  flash_access_granted, cmd_valid, cmd_op, cmd_addr, cmd_data, flash_dq_in,
        output flash_access_request, cmd_ready, op_done, op_error, busy,
               flash_addr, flash_dq_out, flash_dq_oe, flash_nce, flash_nwe, flash_noe
    );

    modport master (
        output flash_access_granted, cmd_valid, cmd_op, cmd_addr, cmd_data, flash_dq_in,
        input  flash_access_request, cmd_ready, op_done, op_error, busy,
               flash_addr, flash_dq_out, flash_dq_oe, flash_nce, flash_nwe, flash_noe
    );
endinterface

// File: rtl/pfl_fl_bus_cycle.sv
// pfl_fl_bus_cycle: single flash read/write cycle timing engine; o_done marks the recovery cycle
module pfl_fl_bus_cycle
    import pfl_fl_pkg::*;
#(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16,
    parameter int T_SETUP = 2,
    parameter int T_WE    = 4,
    parameter int T_RD    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_rd_nwr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_dq_in,
    output logic              o_idle,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_dq_out,
    output logic              o_dq_oe,
    output logic              o_nce,
    output logic              o_nwe,
    output logic              o_noe
);
    localparam int CW = 8;

    bc_phase_t         r_phase, w_phase_next;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    // phase sequencing: write = SETUP, WE, HOLD, REC; read = RD, REC
    always_comb begin
        w_phase_next = r_phase;
        case (r_phase)
            BC_IDLE:  w_phase_next = i_start ? (i_rd_nwr ? BC_RD : BC_SETUP) : BC_IDLE;
            BC_SETUP: w_phase_next = (r_cnt == CW'(T_SETUP - 1)) ? BC_WE : BC_SETUP;
            BC_WE:    w_phase_next = (r_cnt == CW'(T_WE - 1)) ? BC_HOLD : BC_WE;
            BC_HOLD:  w_phase_next = BC_REC;
            BC_RD:    w_phase_next = (r_cnt == CW'(T_RD - 1)) ? BC_REC : BC_RD;
            default:  w_phase_next = BC_IDLE;
        endcase
    end

    // phase/counter state, address/data latch on start, read sample on the last RD cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= BC_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_phase <= w_phase_next;
            r_cnt   <= (w_phase_next == r_phase && r_phase != BC_IDLE) ? r_cnt + 1'b1 : '0;
            if (r_phase == BC_IDLE && i_start) begin
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
            end
            if (r_phase == BC_RD && w_phase_next == BC_REC)
                r_rdata <= i_dq_in;
        end
    end

    assign o_idle   = r_phase == BC_IDLE;
    assign o_done   = r_phase == BC_REC;
    assign o_rdata  = r_rdata;
    assign o_addr   = r_addr;
    assign o_dq_out = r_wdata;
    assign o_dq_oe  = r_phase inside {BC_SETUP, BC_WE, BC_HOLD};
    assign o_nce    = !(r_phase inside {BC_SETUP, BC_WE, BC_HOLD, BC_RD});
    assign o_nwe    = r_phase != BC_WE;
    assign o_noe    = r_phase != BC_RD;
endmodule

// File: rtl/pfl_fl_writer.sv
// pfl_fl_writer: CFI flash word-program / sector-erase engine with DQ7 polling and DQ5 timeout.
// Optional macro PFL_FL_WRITE_VERIFY_EN adds a full-word read-back after a successful program poll.
module pfl_fl_writer
    import pfl_fl_pkg::*;
#(
    parameter int          ADDR_W   = 25,
    parameter int          DATA_W   = 16,
    parameter int          T_SETUP  = 2,
    parameter int          T_WE     = 4,
    parameter int          T_RD     = 4,
    parameter logic [23:0] POLL_MAX = 24'd12000000
) (
    input logic            pfl_clk,
    input logic            pfl_reset,
    pfl_fl_writer_if.slave bus
);
    fl_state_t         r_state, w_state_next, w_succ;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [DATA_W-1:0] r_data, w_wdata, w_rdata;
    logic [23:0]       r_poll, w_poll_sat;
    logic              r_err, r_lost;
    logic              w_accept, w_legal, w_bus_st, w_start, w_abort, w_err_set;
    logic              w_rd, w_bc_idle, w_bc_done, w_prog, w_match;

    assign w_accept   = bus.cmd_valid && r_state == S_IDLE;
    assign w_legal    = bus.cmd_op == OP_PROG || bus.cmd_op == OP_ERASE;
    assign w_prog     = r_op == OP_PROG;
    assign w_bus_st   = r_state inside {S_UNLK1, S_UNLK2, S_CMD, S_DATA, S_ERS3, S_ERS4,
                                        S_ERS5, S_ERS6, S_POLL, S_REREAD, S_VERIFY};
    // a lost grant lets the running cycle finish, then abandons the operation
    assign w_abort    = w_bus_st && (r_lost || !bus.flash_access_granted) && (w_bc_done || w_bc_idle);
    assign w_start    = bus.flash_access_granted && !r_lost && w_bc_idle && (w_bus_st || r_state == S_REQ);
    assign w_match    = w_rdata[7] == (w_prog ? r_data[7] : 1'b1);
    assign w_poll_sat = (r_poll >= POLL_MAX) ? r_poll : r_poll + 24'd1;

`ifdef PFL_FL_WRITE_VERIFY_EN
    assign w_succ = w_prog ? S_VERIFY : S_FIN;
`else
    assign w_succ = S_FIN;
`endif

    // address/data/direction of the bus cycle owned by the current state (REQ pre-issues UNLK1)
    always_comb begin
        w_addr  = r_addr;
        w_wdata = r_data;
        w_rd    = 1'b0;
        case (r_state)
            S_REQ, S_UNLK1, S_ERS4: begin w_addr = ADDR_W'(UNLK_ADDR1); w_wdata = DATA_W'(UNLK_DATA1); end
            S_UNLK2, S_ERS5:        begin w_addr = ADDR_W'(UNLK_ADDR2); w_wdata = DATA_W'(UNLK_DATA2); end
            S_CMD:                  begin w_addr = ADDR_W'(UNLK_ADDR1); w_wdata = DATA_W'(CMD_PROG); end
            S_ERS3:                 begin w_addr = ADDR_W'(UNLK_ADDR1); w_wdata = DATA_W'(CMD_ERASE); end
            S_ERS6:                 w_wdata = DATA_W'(CMD_SECTOR);
            S_POLL, S_REREAD, S_VERIFY: w_rd = 1'b1;
            default: ;
        endcase
    end

    // next-state: advance on each completed bus cycle, decide poll outcome
    always_comb begin
        w_state_next = r_state;
        w_err_set    = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = w_legal ? S_REQ : S_FIN;
            S_REQ:  if (bus.flash_access_granted) w_state_next = S_UNLK1;
            S_FIN:  w_state_next = S_IDLE;
            default: begin
                if (w_abort) begin
                    w_err_set    = 1'b1;
                    w_state_next = S_FIN;
                end else if (w_bc_done) begin
                    case (r_state)
                        S_UNLK1:        w_state_next = S_UNLK2;
                        S_UNLK2:        w_state_next = w_prog ? S_CMD : S_ERS3;
                        S_CMD:          w_state_next = S_DATA;
                        S_DATA, S_ERS6: w_state_next = S_POLL;
                        S_ERS3:         w_state_next = S_ERS4;
                        S_ERS4:         w_state_next = S_ERS5;
                        S_ERS5:         w_state_next = S_ERS6;
                        S_POLL: begin
                            if (w_match)
                                w_state_next = w_succ;
                            else if (w_rdata[5])
                                w_state_next = S_REREAD;
                            else if (w_poll_sat == POLL_MAX) begin
                                w_err_set    = 1'b1;
                                w_state_next = S_FIN;
                            end
                        end
                        S_REREAD: begin
                            w_state_next = w_match ? w_succ : S_FIN;
                            w_err_set    = !w_match;
                        end
                        S_VERIFY: begin
                            w_state_next = S_FIN;
                            w_err_set    = w_rdata != r_data;
                        end
                        default: w_state_next = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    // state register, command latch, sticky error, grant-loss flag and poll counter
    always_ff @(posedge pfl_clk or posedge pfl_reset) begin
        if (pfl_reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_lost  <= 1'b0;
            r_poll  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op   <= bus.cmd_op;
                r_addr <= bus.cmd_addr;
                r_data <= bus.cmd_data;
                r_err  <= !w_legal;
                r_lost <= 1'b0;
                r_poll <= '0;
            end else begin
                if (w_err_set)
                    r_err <= 1'b1;
                if (w_bus_st && !bus.flash_access_granted)
                    r_lost <= 1'b1;
                if (r_state == S_POLL && w_bc_done)
                    r_poll <= w_poll_sat;
            end
        end
    end

    assign bus.cmd_ready            = r_state == S_IDLE;
    assign bus.busy                 = r_state != S_IDLE;
    assign bus.op_done              = r_state == S_FIN;
    assign bus.op_error             = r_err;
    assign bus.flash_access_request = !(r_state inside {S_IDLE, S_FIN});

    pfl_fl_bus_cycle #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .T_SETUP(T_SETUP),
        .T_WE   (T_WE),
        .T_RD   (T_RD)
    ) u_bus_cycle (
        .clk     (pfl_clk),
        .rst     (pfl_reset),
        .i_start (w_start),
        .i_rd_nwr(w_rd),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .i_dq_in (bus.flash_dq_in),
        .o_idle  (w_bc_idle),
        .o_done  (w_bc_done),
        .o_rdata (w_rdata),
        .o_addr  (bus.flash_addr),
        .o_dq_out(bus.flash_dq_out),
        .o_dq_oe (bus.flash_dq_oe),
        .o_nce   (bus.flash_nce),
        .o_nwe   (bus.flash_nwe),
        .o_noe   (bus.flash_noe)
    );
endmodule

// File: tb/tb_pfl_fl_writer.sv
// tb_pfl_fl_writer: directed bench with a behavioural flash poll model and a bus-write log
module tb_pfl_fl_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    pfl_fl_writer_if #(.ADDR_W(25), .DATA_W(16)) bus ();

    pfl_fl_writer #(
        .ADDR_W(25), .DATA_W(16), .T_SETUP(2), .T_WE(4), .T_RD(4), .POLL_MAX(24'd20)
    ) dut (
        .pfl_clk  (clk),
        .pfl_reset(rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // flash model: the first n_low reads return low_val, later reads return high_val
    int          rd_cnt = 0;
    int          n_low = 0;
    logic [15:0] low_val = '0;
    logic [15:0] high_val = '0;
    assign bus.flash_dq_in = (rd_cnt < n_low) ? low_val : high_val;

    always @(posedge bus.flash_noe)
        if (!rst) rd_cnt++;

    // every completed write is logged as {addr, data} when nWE rises
    logic [40:0] wlog[$];
    logic [40:0] ew[$];
    always @(posedge bus.flash_nwe)
        if (!rst && bus.flash_nce === 1'b0) wlog.push_back({bus.flash_addr, bus.flash_dq_out});

    // pulse-width monitor and pin invariants, sampled away from the active edge
    int we_run = 0, last_we = 0, nce_run = 0, last_wr = 0, last_rd = 0, nce_low_cnt = 0, done_cnt = 0;
    bit nce_rd = 0;
    always @(negedge clk) begin
        if (bus.op_done === 1'b1) done_cnt++;
        if (bus.flash_nwe === 1'b0) we_run++;
        else if (we_run != 0) begin last_we = we_run; we_run = 0; end
        if (bus.flash_nce === 1'b0) begin
            nce_run++;
            nce_low_cnt++;
            if (bus.flash_noe === 1'b0) nce_rd = 1;
        end else if (nce_run != 0) begin
            if (nce_rd) last_rd = nce_run; else last_wr = nce_run;
            nce_run = 0;
            nce_rd = 0;
        end
        if (!rst) begin
            assert (!(bus.flash_nwe === 1'b0 && bus.flash_noe === 1'b0)) else begin
                failures++;
                $error("FAIL inv_we_oe nwe=%b noe=%b required not both 0", bus.flash_nwe, bus.flash_noe);
            end
            assert (!(bus.flash_dq_oe === 1'b1 && bus.flash_noe === 1'b0)) else begin
                failures++;
                $error("FAIL inv_oe_noe dq_oe=%b noe=%b required not oe with noe=0", bus.flash_dq_oe, bus.flash_noe);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [24:0] a, input logic [15:0] d);
        wlog.delete();
        rd_cnt = 0;
        done_cnt = 0;
        nce_low_cnt = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_addr = a;
        bus.cmd_data = d;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    bit seen, err_at, req_at;
    task automatic wait_done();
        seen = 0;
        err_at = 0;
        req_at = 1;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (bus.op_done === 1'b1) begin
                seen = 1;
                err_at = bus.op_error;
                req_at = bus.flash_access_request;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_writes(input string tag);
        chk({tag, "_nwr"}, 64'(wlog.size()), 64'(ew.size()));
        for (int i = 0; i < ew.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), (i < wlog.size()) ? wlog[i] : 41'h0, ew[i]);
    endtask

    initial begin
        int viol;
        bit hit;
        bus.flash_access_granted = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00;
        bus.cmd_addr = '0;
        bus.cmd_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_pins", {bus.flash_nce, bus.flash_nwe, bus.flash_noe, bus.flash_dq_oe}, 4'b1110);
        chk("rst_addr_dq", {bus.flash_addr, bus.flash_dq_out}, 41'h0);
        chk("rst_ctrl", {bus.flash_access_request, bus.busy, bus.op_done, bus.op_error, bus.cmd_ready}, 5'b00001);
        rst = 1'b0;
        @(negedge clk);

        // program: DQ7 reads as the complement of data bit 7 while busy, then final data
        n_low = 3; low_val = 16'h0080; high_val = 16'hA55A;
        issue(2'b01, 25'h0001234, 16'hA55A);
        chk("prog_accept", {bus.busy, bus.cmd_ready}, 2'b10);
        wait_done();
        chk("prog_done", seen, 1'b1);
        chk("prog_err", err_at, 1'b0);
        chk("prog_req_at_done", req_at, 1'b0);
        chk("prog_done_cnt", 64'(done_cnt), 64'd1);
        chk("prog_reads", 64'(rd_cnt), 64'd4);
        ew = '{{25'h555, 16'h00AA}, {25'h2AA, 16'h0055}, {25'h555, 16'h00A0}, {25'h1234, 16'hA55A}};
        chk_writes("prog");
        chk("t_we", 64'(last_we), 64'd4);
        chk("t_wr_nce", 64'(last_wr), 64'd7);
        chk("t_rd_nce", 64'(last_rd), 64'd4);
        chk("prog_idle", {bus.cmd_ready, bus.busy, bus.flash_access_request}, 3'b100);

        // sector erase: ten busy reads then erased word
        n_low = 10; low_val = 16'h0000; high_val = 16'hFFFF;
        issue(2'b10, 25'h0100000, 16'h0000);
        wait_done();
        chk("ers_done", seen, 1'b1);
        chk("ers_err", err_at, 1'b0);
        chk("ers_reads", 64'(rd_cnt), 64'd11);
        ew = '{{25'h555, 16'h00AA}, {25'h2AA, 16'h0055}, {25'h555, 16'h0080},
               {25'h555, 16'h00AA}, {25'h2AA, 16'h0055}, {25'h100000, 16'h0030}};
        chk_writes("ers");

        // DQ5 timeout: one re-read, then failure
        n_low = 1000; low_val = 16'h0020; high_val = 16'h0020;
        issue(2'b01, 25'h0000040, 16'h0080);
        wait_done();
        chk("dq5_done", seen, 1'b1);
        chk("dq5_err", err_at, 1'b1);
        chk("dq5_reads", 64'(rd_cnt), 64'd2);
        chk("dq5_released", {bus.flash_access_request, bus.flash_nce}, 2'b01);

        // poll limit (POLL_MAX=20): DQ7 never settles, DQ5 never set
        n_low = 1000; low_val = 16'h0000; high_val = 16'h0000;
        issue(2'b01, 25'h0000041, 16'h0080);
        wait_done();
        chk("pmax_err", {seen, err_at}, 2'b11);
        chk("pmax_reads", 64'(rd_cnt), 64'd20);

        // illegal op: error plus done pulse one cycle after accept, no bus activity
        issue(2'b11, 25'h0000555, 16'h1111);
        chk("ill_pulse", {bus.op_done, bus.op_error, bus.flash_access_request}, 3'b110);
        repeat (4) @(negedge clk);
        chk("ill_quiet", {64'(done_cnt), 64'(nce_low_cnt)}, {64'd1, 64'd0});

        // grant withheld for 50 cycles after accept
        bus.flash_access_granted = 1'b0;
        n_low = 0; high_val = 16'h1234;
        issue(2'b01, 25'h0000300, 16'h1234);
        chk("err_cleared", {bus.op_error, bus.busy, bus.cmd_ready}, 3'b010);
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.flash_nce !== 1'b1 || bus.flash_access_request !== 1'b1) viol++;
        end
        chk("gw_quiet", 64'(viol), 64'd0);
        bus.flash_access_granted = 1'b1;
        @(negedge clk);
        chk("gw_start", bus.flash_nce, 1'b0);
        wait_done();
        chk("gw_done", {seen, err_at}, 2'b10);

        // grant dropped during the first write: cycle completes, then error
        n_low = 0; high_val = 16'h0000;
        issue(2'b01, 25'h0000301, 16'h0000);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (bus.flash_nce === 1'b0) hit = 1; else @(negedge clk);
        end
        bus.flash_access_granted = 1'b0;
        wait_done();
        bus.flash_access_granted = 1'b1;
        chk("gl_done", {hit, seen, err_at, req_at}, 4'b1110);
        chk("gl_writes", 64'(wlog.size()), 64'd1);

        // program 0x00FF; poll read matches, a verify read would return 0x00FE
        n_low = 1; low_val = 16'h00FF; high_val = 16'h00FE;
        issue(2'b01, 25'h0000302, 16'h00FF);
        wait_done();
`ifdef PFL_FL_WRITE_VERIFY_EN
        chk("vfy_result", {seen, err_at, 8'(rd_cnt)}, {2'b11, 8'd2});
`else
        chk("vfy_result", {seen, err_at, 8'(rd_cnt)}, {2'b10, 8'd1});
`endif

        // reset asserted while nWE is low
        n_low = 0; high_val = 16'h0000;
        issue(2'b01, 25'h0000303, 16'h0000);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (bus.flash_nwe === 1'b0) hit = 1; else @(negedge clk);
        end
        chk("rmid_reached", hit, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rmid_pins", {bus.flash_nwe, bus.flash_nce, bus.flash_dq_oe, bus.flash_noe}, 4'b1101);
        chk("rmid_ctrl", {bus.cmd_ready, bus.busy, bus.flash_access_request, bus.op_done}, 4'b1000);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
